// File: rtl/alu_shift_pkg.sv
// Shared constants, op codes and state encoding for the multi-cycle shift/rotate unit.
package alu_shift_pkg;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Right-going ops run on the left-shift datapath with a bit-reversed operand.
    function automatic logic is_right(input logic [2:0] op);
        return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_ROR;
    endfunction
endpackage

// File: rtl/bit_reverse32.sv
// Combinational 32-bit bit reversal assembled from two 16-bit reversers.
module Reverser16 (
    input  logic [15:0] d_i,
    output logic [15:0] d_o
);
    for (genvar i = 0; i < 16; i++) begin : g_rev
        assign d_o[i] = d_i[15-i];
    end
endmodule

module bit_reverse32 (
    input  logic [31:0] d_i,
    output logic [31:0] d_o
);
    // The low half reversed becomes the high half, and vice versa.
    Reverser16 u_rev_lo (.d_i(d_i[15:0]),  .d_o(d_o[31:16]));
    Reverser16 u_rev_hi (.d_i(d_i[31:16]), .d_o(d_o[15:0]));
endmodule

// File: rtl/alu_shift_sequencer.sv
// One-bit-per-clock shift/rotate sequencer with valid/ready handshakes on input and result.
module alu_shift_sequencer
    import alu_shift_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [SHAMT_W-1:0]   shamt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 err
);
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   count_q, count_d;
    logic [2:0]           op_q, op_d;
    logic                 sign_q, sign_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 err_q, err_d;
    logic                 fill;
    logic                 load_result;
    logic [WIDTH-1:0]     a_rev;
    logic [WIDTH-1:0]     work_d_rev;

    bit_reverse32 u_load_rev   (.d_i(a),      .d_o(a_rev));
    bit_reverse32 u_result_rev (.d_i(work_d), .d_o(work_d_rev));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            count_q  <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        count_d     = count_q;
        op_d        = op_q;
        sign_d      = sign_q;
        result_d    = result_q;
        err_d       = err_q;
        fill        = 1'b0;
        load_result = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d   = op;
                    sign_d = a[WIDTH-1];
                    if (is_reserved(op)) begin
                        // Reserved ops pass the operand through untouched.
                        work_d      = a;
                        count_d     = '0;
                        state_d     = ST_DONE;
                        load_result = 1'b1;
                    end else begin
                        work_d  = is_right(op) ? a_rev : a;
                        count_d = shamt;
                        if (shamt != '0) begin
                            state_d = ST_SHIFT;
                        end else begin
                            state_d     = ST_DONE;
                            load_result = 1'b1;
                        end
                    end
                end
            end
            ST_SHIFT: begin
                case (op_q)
                    OP_SRA:         fill = sign_q;
                    OP_ROL, OP_ROR: fill = work_q[WIDTH-1];
                    default:        fill = 1'b0;
                endcase
                work_d  = {work_q[WIDTH-2:0], fill};
                count_d = count_q - 1'b1;
                if (count_q == SHAMT_W'(1)) begin
                    state_d     = ST_DONE;
                    load_result = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Result and err are captured only on entry to DONE so they stay stable under back-pressure.
        if (load_result) begin
            result_d = is_right(op_d) ? work_d_rev : work_d;
            err_d    = is_reserved(op_d);
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign err       = err_q;
endmodule
